led_ctrl_multi: RTL and testbench
=================================

// Module: led_ctrl_multi
// PURPOSE
//   Parametrised multi-channel LED driver; successor to single-channel led_cnt.
//   NUM_CH independent channels, each OFF/ON/BLINK/PWM (optional BREATHE), set via a
//   single-cycle write port driven by AXI-lite register logic. Drives board LEDs directly.
// PARAMETERS
//   NUM_CH   4    number of LED channels (1..16)
//   DIVW     5    width of blink divider exponent; half-period = 2**div cycles
//   PWMW     8    PWM duty/counter width
//   PRESC    4    PWM counter advances once per 2**PRESC clk100 cycles
//   DIV_RST  24   reset value of every channel's div
// PORTS
//   clk100   in   1            system clock
//   rst      in   1            synchronous, active-high reset
//   wren_i   in   1            config write strobe, one cycle per write
//   ch_i     in   CHW          target channel, CHW = max(1,$clog2(NUM_CH))
//   mode_i   in   3            mode_t to write
//   div_i    in   DIVW         blink divider exponent to write
//   duty_i   in   PWMW         PWM duty to write
//   err_o    out  1            1-cycle pulse: write to ch_i >= NUM_CH or unsupported mode
//   led_o    out  NUM_CH       registered LED outputs, 1 = lit
// BEHAVIOUR
//   - Reset: per-channel mode=OFF, div=DIV_RST, duty=0, counters=0; led_o=0, err_o=0.
//     rst mid-operation overrides everything, including a same-cycle write.
//   - Write: on edge where wren_i=1 and ch_i<NUM_CH, channel latches mode/div/duty and clears
//     its blink counter and blink state; led_o reflects new config on the following edge
//     (1-cycle latency). Write beats a same-cycle counter terminal event.
//   - Invalid write (ch_i>=NUM_CH, or mode code unsupported): no state change, err_o=1 next cycle.
//   - Modes (mode_t): OFF=0 led=0; ON=1 led=1; BLINK=2; PWM=3; BREATHE=4; 5..7 unsupported.
//   - BLINK: per-channel counter (2**DIVW-1 bits max) counts 0..2**div-1; at terminal, wraps to 0
//     and led toggles. div=0 -> toggles every cycle. First toggle 2**div cycles after write.
//   - PWM: one shared prescaler (PRESC bits) gives tick; shared PWMW-bit pwm_cnt increments on
//     tick, wraps 2**PWMW-1 -> 0. led = (pwm_cnt < duty). duty=0 -> always off; max duty ->
//     lit 255/256 of period (use ON for full). Duty change effective at next compare.
//   - Shared prescaler/pwm_cnt are free-running; not cleared by writes (only by rst).
//   - Channels fully independent; all NUM_CH may be in different modes simultaneously.
// CONFIGURATION
//   LED_BREATHE_EN defined: mode BREATHE valid; channel behaves as PWM but on each pwm_cnt wrap
//     its duty steps +1 (rising) / -1 (falling); direction reverses on reaching 2**PWMW-1 or 0;
//     write of BREATHE starts rising from duty_i. Write of PWM/other mode freezes duty.
//   LED_BREATHE_EN undefined: BREATHE is unsupported -> write rejected, err_o pulses;
//     no step logic or direction flops synthesised.
// STRUCTURE
//   - led_ctrl_pkg: mode_t enum (3-bit), MODE_* constants, chan_cfg_t struct {mode,div,duty}.
//   - Sub-module led_chan: one channel (cfg regs, blink counter, compare, breathe step);
//     generated NUM_CH times. Top owns prescaler, pwm_cnt, write decode, err_o.
// TESTING
//   - rst held 3 cycles then released -> led_o=0, err_o=0; all channels read mode OFF.
//   - write ch0 BLINK div=2 -> led_o[0] toggles every 4 cycles, first toggle 4 cycles after write.
//   - ch1 PWM duty=64, PRESC=4 -> led_o[1] high 1024 of every 4096 cycles; duty=0 -> never high.
//   - write ch_i=4 with NUM_CH=4 -> err_o one-cycle pulse, led_o unchanged; same for mode=6.
//   - ch2 BLINK div=3 counting, rewrite div=1 at cycle 5 -> counter cleared, toggles every 2 cycles;
//     rst asserted mid-blink -> led_o=0 next edge, div back to DIV_RST.
//   - LED_BREATHE_EN: ch3 BREATHE duty=254 -> duty 255 after 1 wrap, 254 after 2; undefined ->
//     BREATHE write gives err_o pulse, channel keeps prior mode.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared types for the multi-channel LED driver: mode codes, per-channel config record, mode check.
// Build option LED_BREATHE_EN enables the BREATHE mode code.
package led_ctrl_pkg;

    typedef enum logic [2:0] {
        MODE_OFF     = 3'd0,
        MODE_ON      = 3'd1,
        MODE_BLINK   = 3'd2,
        MODE_PWM     = 3'd3,
        MODE_BREATHE = 3'd4
    } mode_t;

    localparam int DIVW_DEF = 5;
    localparam int PWMW_DEF = 8;

    typedef struct packed {
        mode_t               mode;
        logic [DIVW_DEF-1:0] div;
        logic [PWMW_DEF-1:0] duty;
    } chan_cfg_t;

    function automatic logic mode_ok(input logic [2:0] code);
`ifdef LED_BREATHE_EN
        return code <= 3'd4;
`else
        return code <= 3'd3;
`endif
    endfunction

endpackage

// File: rtl/led_ctrl_multi_chan.sv
// One LED channel: config registers, blink counter, PWM compare, optional breathe stepping.
// Latency: led reflects a write one edge later; no backpressure, writes always accepted.
// Build option LED_BREATHE_EN adds the breathe direction flop and duty stepping.
module led_chan
    import led_ctrl_pkg::*;
#(
    parameter int DIVW    = 5,
    parameter int PWMW    = 8,
    parameter int DIV_RST = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr,
    input  mode_t           wr_mode,
    input  logic [DIVW-1:0] wr_div,
    input  logic [PWMW-1:0] wr_duty,
    input  logic [PWMW-1:0] pwm_cnt,
`ifdef LED_BREATHE_EN
    input  logic            pwm_wrap,
`endif
    output logic            led
);

    localparam int BCW = 2**DIVW - 1;

    typedef struct packed {
        mode_t           mode;
        logic [DIVW-1:0] div;
        logic [PWMW-1:0] duty;
    } cfg_t;

    cfg_t           cfg;
    logic [BCW-1:0] blink_cnt;
    logic [BCW-1:0] blink_mask;
    logic           blink;
    logic           blink_term;
    logic           blink_nxt;
    logic           pwm_on;
`ifdef LED_BREATHE_EN
    logic           rising;
`endif

    // Terminal count is 2**div - 1; shifting all-ones left by div clears exactly div low bits.
    assign blink_mask = ~({BCW{1'b1}} << cfg.div);
    assign blink_term = (blink_cnt == blink_mask);
    assign blink_nxt  = blink ^ blink_term;
    assign pwm_on     = (pwm_cnt < cfg.duty);

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg       <= '{mode: MODE_OFF, div: DIVW'(DIV_RST), duty: '0};
            blink_cnt <= '0;
            blink     <= 1'b0;
            led       <= 1'b0;
`ifdef LED_BREATHE_EN
            rising    <= 1'b1;
`endif
        end else begin
            if (wr) begin
                cfg       <= '{mode: wr_mode, div: wr_div, duty: wr_duty};
                blink_cnt <= '0;
                blink     <= 1'b0;
`ifdef LED_BREATHE_EN
                rising    <= 1'b1;
`endif
            end else begin
                if (cfg.mode == MODE_BLINK) begin
                    blink_cnt <= blink_term ? '0 : blink_cnt + BCW'(1);
                    blink     <= blink_nxt;
                end
`ifdef LED_BREATHE_EN
                if (pwm_wrap && cfg.mode == MODE_BREATHE) begin
                    if (rising) begin
                        if (&cfg.duty) begin
                            rising   <= 1'b0;
                            cfg.duty <= cfg.duty - PWMW'(1);
                        end else begin
                            cfg.duty <= cfg.duty + PWMW'(1);
                        end
                    end else if (cfg.duty == '0) begin
                        rising   <= 1'b1;
                        cfg.duty <= cfg.duty + PWMW'(1);
                    end else begin
                        cfg.duty <= cfg.duty - PWMW'(1);
                    end
                end
`endif
            end

            case (cfg.mode)
                MODE_ON:                led <= 1'b1;
                MODE_BLINK:             led <= blink_nxt;
                MODE_PWM, MODE_BREATHE: led <= pwm_on;
                default:                led <= 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/led_ctrl_multi.sv
// Multi-channel LED driver: write decode, shared PWM prescaler/counter, NUM_CH led_chan instances.
// Latency: config write visible on led_o one edge later, err_o one edge after a bad write.
// No backpressure: every write strobe is consumed; build option LED_BREATHE_EN enables BREATHE.
module led_ctrl_multi
    import led_ctrl_pkg::*;
#(
    parameter  int NUM_CH  = 4,
    parameter  int DIVW    = 5,
    parameter  int PWMW    = 8,
    parameter  int PRESC   = 4,
    parameter  int DIV_RST = 24,
    localparam int CHW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk100,
    input  logic              rst,
    input  logic              wren_i,
    input  logic [CHW-1:0]    ch_i,
    input  logic [2:0]        mode_i,
    input  logic [DIVW-1:0]   div_i,
    input  logic [PWMW-1:0]   duty_i,
    output logic              err_o,
    output logic [NUM_CH-1:0] led_o
);

    logic [PRESC-1:0] presc_cnt;
    logic [PWMW-1:0]  pwm_cnt;
    logic             tick;
    logic             ch_ok;
    logic             wr_ok;

    assign tick  = &presc_cnt;
    assign ch_ok = ({1'b0, ch_i} < (CHW+1)'(NUM_CH));
    assign wr_ok = wren_i && ch_ok && mode_ok(mode_i);

`ifdef LED_BREATHE_EN
    logic pwm_wrap;
    assign pwm_wrap = tick && (&pwm_cnt);
`endif

    // Prescaler and PWM counter free-run across config writes so all channels share one phase.
    always_ff @(posedge clk100) begin
        if (rst) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
            err_o     <= 1'b0;
        end else begin
            presc_cnt <= presc_cnt + PRESC'(1);
            if (tick) begin
                pwm_cnt <= pwm_cnt + PWMW'(1);
            end
            err_o <= wren_i && !wr_ok;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        led_chan #(
            .DIVW    (DIVW),
            .PWMW    (PWMW),
            .DIV_RST (DIV_RST)
        ) u_chan (
            .clk      (clk100),
            .rst      (rst),
            .wr       (wr_ok && (ch_i == CHW'(g))),
            .wr_mode  (mode_t'(mode_i)),
            .wr_div   (div_i),
            .wr_duty  (duty_i),
            .pwm_cnt  (pwm_cnt),
`ifdef LED_BREATHE_EN
            .pwm_wrap (pwm_wrap),
`endif
            .led      (led_o[g])
        );
    end

endmodule

// File: tb/tb_led_ctrl_multi.sv
// Bench for led_ctrl_multi: directed steps plus random writes, checked every edge against a
// cycle-index reference model (blink parity, PWM period arithmetic, breathe duty walk).
`timescale 1ns/1ps
module tb_led_ctrl_multi;

    localparam int NUM_CH  = 5;
    localparam int CHW     = 3;
    localparam int DIVW    = 5;
    localparam int PWMW    = 8;
    localparam int PRESC   = 4;
    localparam int DIV_RST = 24;
    localparam int PSTEP   = 1 << PRESC;
    localparam int PLEN    = 1 << PWMW;
    localparam int PER     = PSTEP * PLEN;

    logic              clk100 = 1'b0;
    logic              rst    = 1'b1;
    logic              wren_i = 1'b0;
    logic [CHW-1:0]    ch_i   = '0;
    logic [2:0]        mode_i = '0;
    logic [DIVW-1:0]   div_i  = '0;
    logic [PWMW-1:0]   duty_i = '0;
    logic              err_o;
    logic [NUM_CH-1:0] led_o;

    led_ctrl_multi #(
        .NUM_CH  (NUM_CH),
        .DIVW    (DIVW),
        .PWMW    (PWMW),
        .PRESC   (PRESC),
        .DIV_RST (DIV_RST)
    ) dut (
        .clk100 (clk100),
        .rst    (rst),
        .wren_i (wren_i),
        .ch_i   (ch_i),
        .mode_i (mode_i),
        .div_i  (div_i),
        .duty_i (duty_i),
        .err_o  (err_o),
        .led_o  (led_o)
    );

    always #5 clk100 = ~clk100;

    int checks   = 0;
    int failures = 0;

    // Model state: edge index since reset release, and per-channel config plus write edge.
    int e = 0;
    int m_mode [NUM_CH];
    int m_div  [NUM_CH];
    int m_duty [NUM_CH];
    int m_w    [NUM_CH];
    int m_up   [NUM_CH];
    logic [NUM_CH-1:0] exp_led;
    logic              exp_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic supported(input int m);
`ifdef LED_BREATHE_EN
        return m <= 4;
`else
        return m <= 3;
`endif
    endfunction

    // Led value at edge e, derived from the config in force before that edge.
    function automatic logic model_led(input int c);
        case (m_mode[c])
            1:       return 1'b1;
            2:       return (((e - m_w[c]) >> m_div[c]) & 1) != 0;
            3, 4:    return (((e - 1) / PSTEP) % PLEN) < m_duty[c];
            default: return 1'b0;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk100);
        if (rst) begin
            e       = 0;
            exp_led = '0;
            exp_err = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_mode[c] = 0;
                m_div[c]  = DIV_RST;
                m_duty[c] = 0;
                m_w[c]    = 0;
                m_up[c]   = 1;
            end
        end else begin
            e++;
            for (int c = 0; c < NUM_CH; c++) exp_led[c] = model_led(c);
            exp_err = wren_i && !((ch_i < NUM_CH) && supported(int'(mode_i)));
`ifdef LED_BREATHE_EN
            if (e % PER == 0) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (m_mode[c] == 4) begin
                        if (m_up[c] != 0) begin
                            if (m_duty[c] == PLEN - 1) begin m_up[c] = 0; m_duty[c]--; end
                            else m_duty[c]++;
                        end else begin
                            if (m_duty[c] == 0) begin m_up[c] = 1; m_duty[c]++; end
                            else m_duty[c]--;
                        end
                    end
                end
            end
`endif
            if (wren_i && !exp_err) begin
                m_mode[ch_i] = int'(mode_i);
                m_div[ch_i]  = int'(div_i);
                m_duty[ch_i] = int'(duty_i);
                m_w[ch_i]    = e;
                m_up[ch_i]   = 1;
            end
        end
        #1;
        check("led_o", 32'(led_o), 32'(exp_led));
        check("err_o", 32'(err_o), 32'(exp_err));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wr(input int c, input int m, input int d, input int du);
        ch_i   = CHW'(c);
        mode_i = 3'(m);
        div_i  = DIVW'(d);
        duty_i = PWMW'(du);
        wren_i = 1'b1;
        cyc();
        wren_i = 1'b0;
    endtask

    initial begin
        int lit;

        // Reset held three edges, with a write attempted underneath it.
        rst    = 1'b1;
        wren_i = 1'b1;
        mode_i = 3'd1;
        run(3);
        wren_i = 1'b0;
        rst    = 1'b0;
        run(4);
        check("reset_led", 32'(led_o), 32'd0);
        check("reset_err", 32'(err_o), 32'd0);

        // BLINK div=2: first toggle exactly four edges after the write.
        wr(0, 2, 2, 0);
        run(3);
        check("blink_pre_toggle", 32'(led_o[0]), 32'd0);
        cyc();
        check("blink_first_toggle", 32'(led_o[0]), 32'd1);
        run(4);
        check("blink_second_toggle", 32'(led_o[0]), 32'd0);
        run(20);

        // PWM duty=64: 1024 lit edges in any 4096-edge window.
        wr(1, 3, 0, 64);
        cyc();
        lit = 0;
        for (int i = 0; i < PER; i++) begin
            cyc();
            lit += int'(led_o[1]);
        end
        check("pwm64_lit", 32'(lit), 32'd1024);

        wr(1, 3, 0, 0);
        cyc();
        lit = 0;
        for (int i = 0; i < 600; i++) begin
            cyc();
            lit += int'(led_o[1]);
        end
        check("pwm0_lit", 32'(lit), 32'd0);

        // Invalid channel and unsupported mode: single-cycle error pulse, no state change.
        wr(4, 1, 0, 0);
        wr(5, 1, 0, 0);
        check("bad_ch_err", 32'(err_o), 32'd1);
        cyc();
        check("bad_ch_err_clear", 32'(err_o), 32'd0);
        wr(0, 6, 0, 0);
        check("bad_mode_err", 32'(err_o), 32'd1);
        cyc();
        check("bad_mode_err_clear", 32'(err_o), 32'd0);
        run(10);

        // Rewrite of a counting blink channel restarts its counter.
        wr(2, 2, 3, 0);
        run(4);
        wr(2, 2, 1, 0);
        cyc();
        check("reblink_pre", 32'(led_o[2]), 32'd0);
        cyc();
        check("reblink_toggle", 32'(led_o[2]), 32'd1);
        run(9);

        // Reset mid-operation beats a same-cycle write.
        rst = 1'b1;
        ch_i = 3'd3; mode_i = 3'd1; wren_i = 1'b1;
        cyc();
        wren_i = 1'b0;
        check("mid_reset_led", 32'(led_o), 32'd0);
        rst = 1'b0;
        run(40);
        check("post_reset_led", 32'(led_o), 32'd0);

        // BREATHE from duty 254 on a channel previously ON.
        wr(3, 1, 0, 0);
        run(2);
        wr(3, 4, 0, 254);
`ifdef LED_BREATHE_EN
        check("breathe_err", 32'(err_o), 32'd0);
        run(2 * PER + 300);
`else
        check("breathe_err", 32'(err_o), 32'd1);
        run(20);
        check("breathe_keeps_on", 32'(led_o[3]), 32'd1);
`endif

        // Random writes, including bad channels and unsupported modes.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0)
                wr(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 4)), int'($urandom_range(0, 255)));
            else
                cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
